// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit_deser serial-to-parallel block.
// Defining BIT_DESER_PARITY_EN appends one odd-parity bit to every frame.
package bit_deser_pkg;

    typedef enum logic {
        ST_SHIFT = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int frame_len(input int width);
`ifdef BIT_DESER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bit_deser_shift.sv
// Frame counter and shift register; assembles WIDTH data bits per frame and,
// when BIT_DESER_PARITY_EN is defined, checks the trailing odd-parity bit.
module bit_deser_shift
    import bit_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             accept,
    input  logic             clear,
    output logic             frame_done,
    output logic [WIDTH-1:0] word_now,
    output logic             perr_now,
    output logic [WIDTH-1:0] word_held,
    output logic             perr_held
);

    localparam int F     = frame_len(WIDTH);
    localparam int CNT_W = $clog2(F + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] sreg_shift;
    logic             last_bit;
    logic             is_data;

    // The parity bit is the only frame position at cnt == WIDTH; without
    // parity the counter never gets there, so every bit is a data bit.
    assign last_bit = (cnt_q == CNT_W'(F - 1));
    assign is_data  = (cnt_q != CNT_W'(WIDTH));

    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_shift = {sreg_q[WIDTH-2:0], in_bit};
        end else begin
            sreg_shift = {in_bit, sreg_q[WIDTH-1:1]};
        end
    end

    assign frame_done = accept && !clear && last_bit;
    assign word_now   = is_data ? sreg_shift : sreg_q;
    assign word_held  = sreg_q;

    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        if (clear) begin
            cnt_d  = '0;
            sreg_d = '0;
        end else if (accept) begin
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
            if (is_data) begin
                sreg_d = sreg_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            sreg_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sreg_q <= sreg_d;
        end
    end

`ifdef BIT_DESER_PARITY_EN
    logic par_q, par_d;
    logic perr_held_q, perr_held_d;

    // Error when the XOR over data and parity bits is 0 (odd parity expected).
    assign perr_now  = ~(par_q ^ in_bit);
    assign perr_held = perr_held_q;

    always_comb begin
        par_d       = par_q;
        perr_held_d = perr_held_q;
        if (clear) begin
            par_d = 1'b0;
        end else if (accept) begin
            par_d = last_bit ? 1'b0 : (par_q ^ in_bit);
            if (last_bit) begin
                perr_held_d = perr_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q       <= 1'b0;
            perr_held_q <= 1'b0;
        end else begin
            par_q       <= par_d;
            perr_held_q <= perr_held_d;
        end
    end
`else
    assign perr_now  = 1'b0;
    assign perr_held = 1'b0;
`endif

endmodule

// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer with ready/valid on both sides.
// Optional odd-parity frame checking is enabled by defining BIT_DESER_PARITY_EN.
module bit_deser
    import bit_deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_perr
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_perr_q, out_perr_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             clear;
    logic             frame_done;
    logic [WIDTH-1:0] word_now, word_held;
    logic             perr_now, perr_held;

    assign accept = in_valid && in_ready_q;
    // A word parked in HOLD survives flush; only the partial frame is dropped.
    assign clear  = flush && (state_q == ST_SHIFT);

    bit_deser_shift #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .accept    (accept),
        .clear     (clear),
        .frame_done(frame_done),
        .word_now  (word_now),
        .perr_now  (perr_now),
        .word_held (word_held),
        .perr_held (perr_held)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_perr_d  = out_perr_q;
        case (state_q)
            ST_SHIFT: begin
                if (frame_done) begin
                    if (!out_valid_q || out_ready) begin
                        out_data_d  = word_now;
                        out_perr_d  = perr_now;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_data_d  = word_held;
                    out_perr_d  = perr_held;
                    out_valid_d = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            default: state_d = ST_SHIFT;
        endcase
        in_ready_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SHIFT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_perr_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_perr_q  <= out_perr_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_perr  = out_perr_q;

endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output word width in bits (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 means the first accepted bit lands in out_data[WIDTH-1], 0 means it lands in out_data[0].
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-005 SHALL have port in_bit, input, 1, serial data bit from the upstream stage.
REQ-006 SHALL have port in_valid, input, 1, in_bit is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, block accepts in_bit this cycle.
REQ-008 SHALL have port flush, input, 1, synchronous discard of the partial word.
REQ-009 SHALL have port out_data, output, WIDTH, assembled word.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a word.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes the word.
REQ-012 SHALL have port out_perr, output, 1, parity error flag qualified by out_valid.

Function
REQ-013 SHALL accept a bit exactly when in_valid and in_ready are both 1 in the same cycle.
REQ-014 SHALL hold a frame-length bit counter that counts 0..F-1 and wraps to 0 after the last frame bit; F=WIDTH, or WIDTH+1 with parity (REQ-027).
REQ-015 SHALL run FSM states SHIFT and HOLD; reset state SHIFT.
REQ-016 SHALL move a completed word to the output register on the cycle its last bit is accepted; out_valid rises on the next edge (latency 1 cycle after the last bit).
REQ-017 SHALL drive in_ready=1 in SHIFT; in_ready=0 in HOLD.
REQ-018 SHALL enter HOLD when a frame completes while out_valid=1 and out_ready=0; the completed word stays in the shift register.
REQ-019 SHALL leave HOLD on the cycle out_ready=1: the held word loads the output register, out_valid stays 1, and the FSM returns to SHIFT.
REQ-020 SHALL give full throughput: frame completion with out_valid=1 and out_ready=1 loads the new word with no bubble and stays in SHIFT.
REQ-021 SHALL hold out_data and out_perr stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid after a handshake when no new word loads that cycle.
REQ-023 SHALL clear the counter and the partial word on flush; a bit offered in the flush cycle is discarded; flush does not affect the output register or a word held in HOLD.

Reset
REQ-024 SHALL drive in reset: out_valid=0, out_data=0, out_perr=0, in_ready=0 while rst=0, counter=0, shift register=0, FSM=SHIFT.
REQ-025 SHALL drop a partial or held word when reset asserts mid-operation; no word is emitted afterwards.
REQ-026 SHALL drive in_ready=1 on the first cycle after reset deassertion.

Configuration
REQ-027 SHALL compile frame parity checking in only under macro BIT_DESER_PARITY_EN: F=WIDTH+1, the final bit is odd parity over the data bits, and out_perr=1 with the word when the XOR of all F bits is 0.
REQ-028 SHALL use F=WIDTH when BIT_DESER_PARITY_EN is undefined; out_perr is then constant 0 and the port list is unchanged.

Structure
REQ-029 SHALL place the FSM state enum, the default WIDTH constant and the frame-length function in package bit_deser_pkg.
REQ-030 SHALL implement the shift register and counter in sub-module bit_deser_shift; the FSM and output register stay in bit_deser.

Verification
REQ-031 SHALL check: WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 back-to-back, out_ready=1 -> out_data=8'hB2, out_valid high for 1 cycle, one cycle after the 8th bit.
REQ-032 SHALL check: MSB_FIRST=0, same bits -> out_data=8'h4D.
REQ-033 SHALL check: out_ready=0, 16 bits offered -> first word held; in_ready=0 after the 16th bit; raising out_ready -> second word valid the next cycle; in_ready=1.
REQ-034 SHALL check: flush after 3 bits, then 8 bits of 8'hA5 -> exactly one word, 8'hA5.
REQ-035 SHALL check: rst pulsed low after 5 bits -> outputs zero immediately; no word emitted; a following full frame decodes correctly.
REQ-036 SHALL check with BIT_DESER_PARITY_EN: data 8'h03 + parity 1 -> out_perr=0; data 8'h03 + parity 0 -> out_perr=1.
